// File: rtl/mul_unit.sv
// mul_unit: issue/response wrapper around a 4-stage pipelined 32x32 multiplier.
//
// Decodes RV32M multiply ops, drives the multiplier core, carries op/tag
// sideband in lockstep with the un-stallable core pipeline, selects and
// corrects the result half, and buffers results in an output FIFO. Credit
// based admission reserves a FIFO slot for every in-flight request, so a
// result leaving the core is never dropped.
//
// Optional feature: define MUL_MULHSU_EN to build the MULHSU correction
// subtractor. Without it MULHSU returns data 0 with resp_illegal set.
//
// Parameters:
//   TAG_W       width of request/response tag
//   FIFO_DEPTH  output FIFO entries = max outstanding requests (1..16)
//
// Ports:
//   clk, rstn                          clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_op                             00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_s, req_t, req_tag              rs1, rs2, opaque id
//   resp_valid/resp_ready              response handshake
//   resp_data, resp_tag, resp_illegal  FIFO head entry

// Multiplier core: 4 register stages, no stall, no reset on the datapath.
// Ports: clk, is_signed (both operands signed), s, t, d = full 64-bit product.
module mul (
  input  logic        clk,
  input  logic        is_signed,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic [63:0] d
);
  logic [32:0] a1, b1;
  logic [49:0] pl2, ph2;
  logic [63:0] p3;
  logic [49:0] ax, bl, bh;

  // 33-bit operands cover signed and unsigned forms; the product is split
  // into two 33x17 partial products (low and high half of b).
  always_comb begin
    ax = {{17{a1[32]}}, a1};
    bl = {33'b0, b1[15:0]};
    bh = {{33{b1[32]}}, b1[32:16]};
  end

  always_ff @(posedge clk) begin
    a1  <= {is_signed & s[31], s};
    b1  <= {is_signed & t[31], t};
    pl2 <= ax * bl;
    ph2 <= ax * bh;
    p3  <= {{14{pl2[49]}}, pl2} + ({{14{ph2[49]}}, ph2} << 16);
    d   <= p3;
  end
endmodule

module mul_unit #(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_s,
  input  logic [31:0]      req_t,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_illegal
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  logic        accept, deq, wr;
  logic [63:0] core_d;

  assign accept = req_valid && req_ready;

  mul u_core (
    .clk       (clk),
    .is_signed (req_op == OP_MULH),
    .s         (req_s),
    .t         (req_t),
    .d         (core_d)
  );

  // Sideband pipeline, aligned so stage 3 matches core_d.
  logic [3:0]       sb_valid;
  op_e              sb_op  [4];
  logic [TAG_W-1:0] sb_tag [4];
`ifdef MUL_MULHSU_EN
  logic             sb_s31 [4];
  logic [31:0]      sb_t   [4];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sb_valid <= '0;
    else       sb_valid <= {sb_valid[2:0], accept};
  end

  always_ff @(posedge clk) begin
    sb_op[0]  <= op_e'(req_op);
    sb_tag[0] <= req_tag;
`ifdef MUL_MULHSU_EN
    sb_s31[0] <= req_s[31];
    sb_t[0]   <= req_t;
`endif
    for (int unsigned i = 1; i < 4; i++) begin
      sb_op[i]  <= sb_op[i-1];
      sb_tag[i] <= sb_tag[i-1];
`ifdef MUL_MULHSU_EN
      sb_s31[i] <= sb_s31[i-1];
      sb_t[i]   <= sb_t[i-1];
`endif
    end
  end

  // Result select and MULHSU correction.
  logic [31:0] res_data;
  logic        res_ill;

  always_comb begin
    res_data = '0;
    res_ill  = 1'b0;
    case (sb_op[3])
      OP_MUL:            res_data = core_d[31:0];
      OP_MULH, OP_MULHU: res_data = core_d[63:32];
      OP_MULHSU: begin
`ifdef MUL_MULHSU_EN
        // Unsigned product high half, minus t when s is negative.
        res_data = core_d[63:32] - (sb_s31[3] ? sb_t[3] : 32'd0);
`else
        res_ill  = 1'b1;
`endif
      end
      default: res_data = '0;
    endcase
  end

  // Output FIFO.
  logic [31:0]      mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
  logic             mem_ill  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count, outstanding;
  logic [31:0]      last_data;
  logic [TAG_W-1:0] last_tag;
  logic             last_ill;

  assign wr         = sb_valid[3];
  assign resp_valid = (fifo_count != '0);
  assign deq        = resp_valid && resp_ready;
  assign req_ready  = (outstanding < CNT_W'(FIFO_DEPTH));

  // When empty the outputs hold the last dequeued entry.
  assign resp_data    = resp_valid ? mem_data[rd_ptr] : last_data;
  assign resp_tag     = resp_valid ? mem_tag[rd_ptr]  : last_tag;
  assign resp_illegal = resp_valid ? mem_ill[rd_ptr]  : last_ill;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr] <= res_data;
      mem_tag[wr_ptr]  <= sb_tag[3];
      mem_ill[wr_ptr]  <= res_ill;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      last_data   <= '0;
      last_tag    <= '0;
      last_ill    <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (deq) begin
        rd_ptr    <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        last_data <= mem_data[rd_ptr];
        last_tag  <= mem_tag[rd_ptr];
        last_ill  <= mem_ill[rd_ptr];
      end
      case ({wr, deq})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({accept, deq})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 8;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

`ifdef MUL_MULHSU_EN
  localparam logic [31:0] HSU_A = 32'hFFFF_FFFF;
  localparam logic [31:0] HSU_B = 32'h8000_0000;
  localparam logic        HSU_ILL = 1'b0;
`else
  localparam logic [31:0] HSU_A = 32'h0;
  localparam logic [31:0] HSU_B = 32'h0;
  localparam logic        HSU_ILL = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_s, req_t;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_illegal;

  mul_unit #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_s        (req_s),
    .req_t        (req_t),
    .req_tag      (req_tag),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_tag     (resp_tag),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Scoreboard: every handshaken response must match the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", resp_data, mon_e.data);
        check("resp_tag", resp_tag, mon_e.tag);
        check("resp_illegal", resp_illegal, mon_e.ill);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] s, input logic [31:0] t,
                       input logic [TAG_W-1:0] tag, input logic [31:0] want, input logic ill);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_s     = s;
    req_t     = t;
    req_tag   = tag;
    @(posedge clk);
    e.data = want;
    e.tag  = tag;
    e.ill  = ill;
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  // Issue with resp_ready high and check resp_valid rises exactly 5 cycles later.
  task automatic latency_check(input logic [1:0] op, input logic [31:0] s, input logic [31:0] t,
                               input logic [TAG_W-1:0] tag, input logic [31:0] want);
    issue(op, s, t, tag, want, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("latency_valid", resp_valid, (i == 5) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic fill(input int unsigned f);
    int unsigned acc = 0;
    logic        rdy;
    exp_t        e;
    logic [31:0] s, t;
    resp_ready = 1'b0;
    for (int c = 0; c < int'(DEPTH) + 4; c++) begin
      @(negedge clk);
      rdy       = req_ready;
      s         = acc + 16 * f + 1;
      t         = acc + 3;
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_s     = s;
      req_t     = t;
      req_tag   = acc[TAG_W-1:0];
      @(posedge clk);
      if (rdy) begin
        e.data = s * t;
        e.tag  = acc[TAG_W-1:0];
        e.ill  = 1'b0;
        exp_q.push_back(e);
        acc++;
      end
    end
    #1 req_valid = 1'b0;
    check("bp_accepts", acc, DEPTH);
    @(negedge clk);
    check("bp_ready_low", req_ready, 0);
    repeat (6) @(negedge clk);
    check("bp_full_valid", resp_valid, 1);
    check("bp_head_tag", resp_tag, 0);
    check("bp_head_data", resp_data, (16 * f + 1) * 3);
    @(negedge clk);
    check("bp_hold_tag", resp_tag, 0);
    check("bp_hold_data", resp_data, (16 * f + 1) * 3);
    check("bp_ready_held", req_ready, 0);
    resp_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("bp_ready_back", req_ready, 1);
    check("bp_empty", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_s      = '0;
    req_t      = '0;
    req_tag    = '0;
    resp_ready = 1'b1;
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    @(negedge clk);
    rstn = 1'b1;

    latency_check(OP_MUL, 32'd7, 32'd6, 4'd3, 32'h0000_002A);
    wait_drain();

    issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h0000_0000, 1'b0);
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 4'd2, 32'h4000_0000, 1'b0);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE, 1'b0);
    issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'h0000_0001, 1'b0);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 4'd6, HSU_A, HSU_ILL);
    issue(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, HSU_B, HSU_ILL);
    issue(OP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 4'd8, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MUL,    32'h1234_5678, 32'h0000_0010, 4'd9, 32'h2345_6780, 1'b0);
    wait_drain();

    for (int unsigned f = 0; f < 3; f++) fill(f);

    // Reset with two results queued and three in flight.
    resp_ready = 1'b0;
    issue(OP_MUL, 32'd2, 32'd2, 4'd1, 32'd4, 1'b0);
    issue(OP_MUL, 32'd3, 32'd3, 4'd2, 32'd9, 1'b0);
    repeat (7) @(negedge clk);
    issue(OP_MUL, 32'd4, 32'd4, 4'd3, 32'd16, 1'b0);
    issue(OP_MUL, 32'd5, 32'd5, 4'd4, 32'd25, 1'b0);
    issue(OP_MUL, 32'd6, 32'd6, 4'd5, 32'd36, 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rstn       = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_idle", resp_valid, 0);
    end
    latency_check(OP_MUL, 32'd3, 32'd5, 4'd5, 32'd15);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
